// File: rtl/cluster_mean_sequencer.sv
// rtl/cluster_mean_sequencer.sv - per-cluster sum/count accumulator and divide sequencer
//
// Accumulates labelled points into per-cluster sums and member counts. When the last
// point of an iteration is seen, it walks clusters 0..K-1 and issues one divide per
// cluster (sum / count) to an external fixed-latency divider. Each mean is emitted with
// its cluster index. An empty cluster emits 0 without using the divider.
//
// Build option: KMEANS_ROUND_EN
//   defined   : dividend = sat(sum + (count >> 1)), which gives a round-to-nearest mean
//   undefined : dividend = sum, which gives a truncating mean
//   Timing is the same in both builds.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   clear                      synchronous abort: zero all sums and counts, return to IDLE
//   pt_valid/pt_data/
//   pt_cluster/pt_last         point stream; pt_last marks the final point of an iteration
//   div_ce, div_sclr           divider clock enable and synchronous clear
//   div_dividend, div_divisor  divider operands for the current cluster
//   div_quotient               divider result
//   mean_valid/mean_idx/
//   mean_data                  one-cycle strobe carrying a cluster mean
//   busy                       high while divides are being sequenced; points are ignored
//   done                       one-cycle pulse after the last mean
//   ovf                        sticky flag: a sum, count or rounded dividend saturated
module cluster_mean_sequencer #(
  parameter int K       = 4,
  parameter int DATA_W  = 8,
  parameter int SUM_W   = 20,
  parameter int CNT_W   = 12,
  parameter int DIV_LAT = 24,
  localparam int CW     = $clog2(K)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              pt_valid,
  input  logic [DATA_W-1:0] pt_data,
  input  logic [CW-1:0]     pt_cluster,
  input  logic              pt_last,
  output logic              div_ce,
  output logic              div_sclr,
  output logic [SUM_W-1:0]  div_dividend,
  output logic [CNT_W-1:0]  div_divisor,
  input  logic [SUM_W-1:0]  div_quotient,
  output logic              mean_valid,
  output logic [CW-1:0]     mean_idx,
  output logic [SUM_W-1:0]  mean_data,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int LW = $clog2(DIV_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [LW-1:0]    wcnt_q, wcnt_d;
  logic [SUM_W-1:0] sum_q [K];
  logic [CNT_W-1:0] cnt_q [K];
  logic             ovf_q;

  logic             pt_in_range, accept_pt, acc_wr, acc_sat;
  logic [SUM_W-1:0] sel_sum, sum_next, cur_sum, dividend_calc;
  logic [CNT_W-1:0] sel_cnt, cnt_next, cur_cnt;
  logic [SUM_W:0]   sum_add;
  logic             rnd_sat, last_idx, wait_end, cur_empty;

  // Accumulate path: a point is taken only while collecting and never on a clear cycle.
  assign pt_in_range = ({1'b0, pt_cluster} < (CW + 1)'(K));
  assign accept_pt   = pt_valid && !clear && (state_q == S_IDLE || state_q == S_ACCUM);
  assign acc_wr      = accept_pt && pt_in_range;
  assign sel_sum     = sum_q[pt_cluster];
  assign sel_cnt     = cnt_q[pt_cluster];
  assign sum_add     = {1'b0, sel_sum} + (SUM_W + 1)'(pt_data);
  assign sum_next    = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
  assign cnt_next    = (&sel_cnt) ? sel_cnt : sel_cnt + 1'b1;
  assign acc_sat     = sum_add[SUM_W] || (&sel_cnt);

  // Divide path: operands come straight from the registers of the current cluster.
  // They cannot change while busy because points are dropped then.
  assign cur_sum   = sum_q[idx_q];
  assign cur_cnt   = cnt_q[idx_q];
  assign cur_empty = (cur_cnt == '0);
  assign last_idx  = (idx_q == CW'(K - 1));
  assign wait_end  = (wcnt_q == LW'(DIV_LAT));

`ifdef KMEANS_ROUND_EN
  logic [SUM_W:0] rnd_sum;
`endif

  always_comb begin
    dividend_calc = cur_sum;
    rnd_sat       = 1'b0;
`ifdef KMEANS_ROUND_EN
    rnd_sum       = {1'b0, cur_sum} + (SUM_W + 1)'(cur_cnt >> 1);
    rnd_sat       = rnd_sum[SUM_W];
    dividend_calc = rnd_sum[SUM_W] ? '1 : rnd_sum[SUM_W-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (pt_valid) state_d = pt_last ? S_ISSUE : S_ACCUM;
      end
      S_ACCUM: begin
        idx_d = '0;
        if (pt_valid && pt_last) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wcnt_d = '0;
        if (!cur_empty) begin
          state_d = S_WAIT;
        end else if (last_idx) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_end) begin
          if (last_idx) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      idx_d   = '0;
      wcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < K; k++) begin
        sum_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (clear || state_q == S_DONE) begin
      for (int k = 0; k < K; k++) begin
        sum_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      if (acc_wr) begin
        sum_q[pt_cluster] <= sum_next;
        cnt_q[pt_cluster] <= cnt_next;
      end
      if ((acc_wr && acc_sat) || (state_q == S_ISSUE && rnd_sat)) ovf_q <= 1'b1;
    end
  end

  // The final WAIT cycle (counter at DIV_LAT) carries no enable: the quotient is
  // already valid there and is passed through as the mean.
  assign busy         = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign div_ce       = !clear && (state_q == S_WAIT) && !wait_end;
  assign div_sclr     = clear || (state_q == S_IDLE && pt_valid);
  assign div_dividend = busy ? dividend_calc : '0;
  assign div_divisor  = busy ? cur_cnt : '0;
  assign mean_valid   = !clear && (((state_q == S_ISSUE) && cur_empty) ||
                                   ((state_q == S_WAIT) && wait_end));
  assign mean_idx     = mean_valid ? idx_q : '0;
  assign mean_data    = (mean_valid && state_q == S_WAIT) ? div_quotient : '0;
  assign done         = !clear && (state_q == S_DONE);
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_cluster_mean_sequencer.sv
// tb/tb_cluster_mean_sequencer.sv - bench for cluster_mean_sequencer
module tb_cluster_mean_sequencer;
  localparam int K = 4, DATA_W = 8, SUM_W = 20, CNT_W = 12, DIV_LAT = 24;
  localparam int MAX_SUM = (1 << SUM_W) - 1;
  localparam int MAX_CNT = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, pt_valid = 1'b0, pt_last = 1'b0;
  logic [DATA_W-1:0] pt_data = '0;
  logic [1:0] pt_cluster = '0;
  logic div_ce, div_sclr, mean_valid, busy, done, ovf;
  logic [SUM_W-1:0] div_dividend, div_quotient, mean_data;
  logic [CNT_W-1:0] div_divisor;
  logic [1:0] mean_idx;

  cluster_mean_sequencer #(.K(K), .DATA_W(DATA_W), .SUM_W(SUM_W), .CNT_W(CNT_W), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .pt_valid(pt_valid), .pt_data(pt_data),
    .pt_cluster(pt_cluster), .pt_last(pt_last), .div_ce(div_ce), .div_sclr(div_sclr),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_quotient(div_quotient),
    .mean_valid(mean_valid), .mean_idx(mean_idx), .mean_data(mean_data), .busy(busy),
    .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Divider: a clock-enabled pipeline of DIV_LAT stages, so the quotient appears only
  // after exactly DIV_LAT enabled edges.
  logic [SUM_W-1:0] pipe [DIV_LAT];
  always @(posedge clk) begin
    if (div_ce) begin
      pipe[0] <= (div_divisor == '0) ? '0 : div_dividend / {{(SUM_W-CNT_W){1'b0}}, div_divisor};
      for (int i = 1; i < DIV_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign div_quotient = pipe[DIV_LAT-1];

  typedef struct {
    bit busy; bit ce; bit mv; bit done; bit ovf_chk; bit ovf;
    int cl; int data; int dvd; int dvs;
  } exp_t;

  exp_t q[$];
  int   m_sum [K];
  int   m_cnt [K];
  bit   m_ovf, in_iter, exp_sclr, run;
  int   checks, errors;
  int   got_mean [K];
  int   got_ovf;

  function automatic exp_t mk(bit b, bit ce, bit mv, bit dn, int cl, int data, int dvd, int dvs);
    exp_t e;
    e.busy = b; e.ce = ce; e.mv = mv; e.done = dn; e.ovf_chk = 1'b0; e.ovf = 1'b0;
    e.cl = cl; e.data = data; e.dvd = dvd; e.dvs = dvs;
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < K; c++) begin m_sum[c] = 0; m_cnt[c] = 0; end
    m_ovf = 1'b0;
    in_iter = 1'b0;
  endfunction

  function automatic void model_point(int c, int d);
    m_sum[c] += d;
    if (m_sum[c] > MAX_SUM) begin m_sum[c] = MAX_SUM; m_ovf = 1'b1; end
    if (m_cnt[c] == MAX_CNT) m_ovf = 1'b1;
    else m_cnt[c] += 1;
  endfunction

  // Expected per-cycle output timeline of one sequencing pass, starting with the
  // cycle in which pt_last is presented.
  function automatic void build_timeline();
    exp_t e;
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < K; c++) begin
      int dvd;
      dvd = m_sum[c];
`ifdef KMEANS_ROUND_EN
      if (m_cnt[c] != 0) begin
        dvd = m_sum[c] + m_cnt[c] / 2;
        if (dvd > MAX_SUM) begin dvd = MAX_SUM; m_ovf = 1'b1; end
      end
`endif
      if (m_cnt[c] == 0) begin
        q.push_back(mk(1, 0, 1, 0, c, 0, dvd, 0));
      end else begin
        q.push_back(mk(1, 0, 0, 0, c, 0, dvd, m_cnt[c]));
        for (int i = 0; i < DIV_LAT; i++) q.push_back(mk(1, 1, 0, 0, c, 0, dvd, m_cnt[c]));
        q.push_back(mk(1, 0, 1, 0, c, dvd / m_cnt[c], dvd, m_cnt[c]));
      end
    end
    e = mk(0, 0, 0, 1, 0, 0, 0, 0);
    e.ovf_chk = 1'b1;
    e.ovf = m_ovf;
    q.push_back(e);
    model_reset();
  endfunction

  task automatic drive(bit v, int c, int d, bit l, bit clr);
    exp_t e;
    @(posedge clk); #1;
    pt_valid = v; pt_cluster = 2'(c); pt_data = 8'(d); pt_last = l; clear = clr;
    exp_sclr = clr || (v && q.size() == 0 && !in_iter);
    if (clr) begin
      if (q.size() > 0) begin
        e = q[0];
        e.ce = 1'b0; e.mv = 1'b0; e.done = 1'b0; e.ovf_chk = 1'b0;
        q.delete();
        q.push_back(e);
      end
      model_reset();
    end else if (v && q.size() == 0) begin
      in_iter = 1'b1;
      if (c < K) model_point(c, d);
      if (l) build_timeline();
    end
  endtask

  task automatic idle();
    drive(0, $urandom_range(0, 3), $urandom_range(0, 255), 0, 0);
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 1000) begin idle(); n++; end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL %s_timeout actual pending %0d expected 0", name, q.size());
      q.delete();
    end
    idle();
  endtask

  function automatic int pick(int mask);
    int c;
    c = $urandom_range(0, 3);
    while (!mask[c]) c = $urandom_range(0, 3);
    return c;
  endfunction

  initial begin : cmp
    exp_t e;
    forever begin
      @(negedge clk);
      if (run) begin
        if (q.size() > 0) e = q.pop_front();
        else e = mk(0, 0, 0, 0, 0, 0, 0, 0);
        chk("busy", busy, e.busy);
        chk("div_ce", div_ce, e.ce);
        chk("mean_valid", mean_valid, e.mv);
        chk("done", done, e.done);
        chk("div_sclr", div_sclr, exp_sclr);
        chk("div_dividend", div_dividend, e.dvd);
        chk("div_divisor", div_divisor, e.dvs);
        if (e.mv) begin
          chk("mean_idx", mean_idx, e.cl);
          chk("mean_data", mean_data, e.data);
          got_mean[e.cl] = mean_data;
        end
        if (e.ovf_chk) begin
          chk("ovf", ovf, e.ovf);
          got_ovf = ovf;
        end
      end
    end
  end

  initial begin : main
    int n, it, np, mask, clr_at;
    bit do_clr;
    checks = 0; errors = 0; run = 1'b0; exp_sclr = 1'b0; got_ovf = -1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_div_ce", div_ce, 0);
    chk("rst_div_sclr", div_sclr, 0);
    chk("rst_mean_valid", mean_valid, 0);
    chk("rst_mean_idx", mean_idx, 0);
    chk("rst_mean_data", mean_data, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dividend", div_dividend, 0);
    chk("rst_divisor", div_divisor, 0);
    rst_n = 1'b1;
    run = 1'b1;

    // Three points, two clusters left empty.
    for (int c = 0; c < K; c++) got_mean[c] = -1;
    drive(1, 0, 10, 0, 0); drive(1, 0, 20, 0, 0); drive(1, 1, 7, 1, 0);
    drain("t1");
    chk("t1_mean0", got_mean[0], 15);
    chk("t1_mean1", got_mean[1], 7);
    chk("t1_mean2", got_mean[2], 0);
    chk("t1_mean3", got_mean[3], 0);

    // Rounding vs truncation on sum 7 / count 2.
    drive(1, 0, 3, 0, 0); drive(1, 0, 4, 1, 0);
    drain("t2");
`ifdef KMEANS_ROUND_EN
    chk("t2_mean0", got_mean[0], 4);
`else
    chk("t2_mean0", got_mean[0], 3);
`endif

    // Clear while cluster 1 is in its divide wait: no mean for cluster 1.
    for (int c = 0; c < K; c++) got_mean[c] = -1;
    drive(1, 0, 50, 0, 0); drive(1, 1, 9, 1, 0);
    n = 0;
    while (!(q.size() > 0 && q[0].ce && q[0].cl == 1) && n < 200) begin idle(); n++; end
    repeat (5) idle();
    drive(0, 0, 0, 0, 1);
    repeat (4) idle();
    chk("t4_mean0", got_mean[0], 50);
    chk("t4_no_mean1", got_mean[1], -1);

    // pt_last in IDLE, then points thrown at the busy sequencer must be dropped.
    drive(1, 2, 100, 1, 0);
    repeat (10) drive(1, 2, 200, 0, 0);
    drive(1, 2, 200, 1, 0);
    drain("t5a");
    drive(1, 2, 30, 1, 0);
    drain("t5b");
    chk("t5_mean2", got_mean[2], 30);

    // Saturation of both count and sum for cluster 2.
    got_ovf = -1;
    for (int i = 0; i < 4200; i++) drive(1, 2, 255, 0, 0);
    drive(1, 2, 255, 1, 0);
    drain("t3");
    chk("t3_mean2", got_mean[2], 256);
    chk("t3_ovf", got_ovf, 1);

    // Randomized iterations with traffic while busy and occasional clears.
    for (it = 0; it < 30; it++) begin
      np = $urandom_range(0, 20);
      mask = $urandom_range(1, 15);
      for (int p = 0; p < np; p++) begin
        if ($urandom_range(0, 3) == 0) idle();
        drive(1, pick(mask), $urandom_range(0, 255), 0, 0);
      end
      drive(1, pick(mask), $urandom_range(0, 255), 1, 0);
      do_clr = ($urandom_range(0, 5) == 0);
      clr_at = $urandom_range(1, 60);
      n = 0;
      while (q.size() > 0 && n < 1000) begin
        if (do_clr && n == clr_at) drive(0, 0, 0, 0, 1);
        else drive($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 255),
                   $urandom_range(0, 1), 0);
        n++;
      end
      drain("rand");
    end

    repeat (3) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
